hamming_frame_spi_tx: RTL and testbench

- Downstream neighbour of the slave-side Hamming encoder: consumes its 12-bit codeword and qvld-style valid level, and serialises the codeword to the SPI master over MISO.
- Holds one pending codeword, loads a shift register at chip-select assertion, and shifts MSB-first in SPI mode 0.
- The SPI pins are oversampled and synchronised into the single system clock domain; there is no second clock.

---
 rtl/hamming_spi_pkg.sv | 10 +
 rtl/spi_edge_sync.sv | 29 ++
 rtl/hamming_frame_spi_tx.sv | 105 ++++++++++
 tb/tb_hamming_frame_spi_tx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_spi_pkg.sv
// Shared constants and FSM state type for the Hamming codeword SPI transmitter.
package hamming_spi_pkg;

   localparam int              CW_W      = 12;
   localparam logic [CW_W-1:0] IDLE_WORD = 12'h000;
   localparam int              BITCNT_W  = $clog2(CW_W + 2);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchroniser for an asynchronous SPI pin with one-cycle rise/fall pulses.
module spi_edge_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic IDLE_VAL    = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{IDLE_VAL}};
         prev_q <= IDLE_VAL;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/hamming_frame_spi_tx.sv
// Serialises one pending Hamming codeword per SPI frame (mode 0, MSB first) over miso.
// Build option: HAMMING_TX_PARITY_TRAILER_EN appends an even-parity bit after the LSB.
module hamming_frame_spi_tx #(
   parameter int              CW_W        = hamming_spi_pkg::CW_W,
   parameter int              SYNC_STAGES = 2,
   parameter logic [CW_W-1:0] IDLE_WORD   = hamming_spi_pkg::IDLE_WORD
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            EN,
   input  logic [CW_W-1:0] code_in,
   input  logic            code_vld,
   input  logic            flag_clr,
   input  logic            sclk,
   input  logic            cs_n,
   output logic            miso,
   output logic            tx_busy,
   output logic            frame_done,
   output logic            ovf,
   output logic            udf
);
   import hamming_spi_pkg::*;

`ifdef HAMMING_TX_PARITY_TRAILER_EN
   localparam int FRAME_BITS = CW_W + 1;
`else
   localparam int FRAME_BITS = CW_W;
`endif
   localparam int CNT_W = $clog2(CW_W + 2);

   state_t                state, state_nxt;
   logic [CW_W-1:0]       hold_q;
   logic                  hold_full;
   logic [FRAME_BITS-1:0] shreg;
   logic [CNT_W-1:0]      bit_cnt;
   logic                  vld_q;
   logic                  sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic                  cap, load, last_rise;
   logic [CW_W-1:0]       src_word;
   logic [FRAME_BITS-1:0] load_word;

   spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sclk_sync (
      .clk(clk), .rst(rst), .din(sclk), .rise(sclk_rise), .fall(sclk_fall));

   spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_cs_sync (
      .clk(clk), .rst(rst), .din(cs_n), .rise(cs_rise), .fall(cs_fall));

   assign cap       = EN & code_vld & ~vld_q;
   assign load      = (state == LOAD);
   assign last_rise = (state == SHIFT) && sclk_rise && (bit_cnt == CNT_W'(FRAME_BITS - 1));
   assign src_word  = hold_full ? hold_q : IDLE_WORD;

`ifdef HAMMING_TX_PARITY_TRAILER_EN
   assign load_word = {src_word, ^src_word};
`else
   assign load_word = src_word;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cs_fall) state_nxt = LOAD;
         LOAD:    state_nxt = SHIFT;
         SHIFT:   if (last_rise) state_nxt = DONE;
         DONE:    state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
      // cs_n deassertion ends the frame from any state; before DONE this is an abort
      if (cs_rise) state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         vld_q      <= 1'b0;
         hold_q     <= '0;
         hold_full  <= 1'b0;
         shreg      <= '0;
         bit_cnt    <= '0;
         frame_done <= 1'b0;
         ovf        <= 1'b0;
         udf        <= 1'b0;
      end else begin
         state      <= state_nxt;
         vld_q      <= code_vld;
         frame_done <= (state == SHIFT) && (state_nxt == DONE);
         if (cap) hold_q <= code_in;
         // A capture coinciding with LOAD refills the hold after the old word moves out
         hold_full  <= cap | (hold_full & ~load);
         ovf        <= (cap & hold_full & ~load) | (ovf & ~flag_clr);
         udf        <= (load & ~hold_full) | (udf & ~flag_clr);
         if (load) begin
            shreg   <= load_word;
            bit_cnt <= '0;
         end else if (state == SHIFT || state == DONE) begin
            if (sclk_rise && state == SHIFT) bit_cnt <= bit_cnt + 1'b1;
            if (sclk_fall) shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
         end
      end
   end

   assign tx_busy = (state != IDLE);
   assign miso    = (state == SHIFT || state == DONE) ? shreg[FRAME_BITS-1] : 1'b0;

endmodule

// File: tb/tb_hamming_frame_spi_tx.sv
// Scoreboard bench: stimulus queues expected frames, a monitor checks them on frame_done.
module tb_hamming_frame_spi_tx;

`ifdef HAMMING_TX_PARITY_TRAILER_EN
   localparam int NB = 13;
   function automatic logic [15:0] frame_of(input logic [11:0] w);
      return 16'({w, ^w});
   endfunction
`else
   localparam int NB = 12;
   function automatic logic [15:0] frame_of(input logic [11:0] w);
      return 16'(w);
   endfunction
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        EN = 1'b1;
   logic [11:0] code_in = '0;
   logic        code_vld = 1'b0;
   logic        flag_clr = 1'b0;
   logic        sclk = 1'b0;
   logic        cs_n = 1'b1;
   logic        miso, tx_busy, frame_done, ovf, udf;

   int          tests = 0;
   int          fails = 0;
   int          done_cnt = 0;
   logic [15:0] exp_q[$];
   logic [15:0] samp = '0;
   logic [15:0] last_frame = '0;
   int          nsamp = 0;
   logic        fd_prev = 1'b0;

   hamming_frame_spi_tx dut (
      .clk(clk), .rst(rst), .EN(EN), .code_in(code_in), .code_vld(code_vld),
      .flag_clr(flag_clr), .sclk(sclk), .cs_n(cs_n), .miso(miso),
      .tx_busy(tx_busy), .frame_done(frame_done), .ovf(ovf), .udf(udf));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Master-side sampler: mode 0 samples miso on rising sclk; cs_n fall starts a frame
   always @(negedge cs_n, posedge sclk) begin
      if (sclk) begin
         if (!cs_n) begin
            samp  = {samp[14:0], miso};
            nsamp = nsamp + 1;
         end
      end else begin
         samp  = '0;
         nsamp = 0;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (frame_done === 1'b1) begin
            done_cnt++;
            chk("frame_done_width", 16'(fd_prev), 16'd0);
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_frame: got %h expected none", samp);
            end else begin
               chk("frame_bits", samp, exp_q.pop_front());
               chk("frame_len", 16'(nsamp), 16'(NB));
            end
            last_frame = samp;
         end
         fd_prev = (frame_done === 1'b1);
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_cw(input logic [11:0] w);
      code_in  = w;
      code_vld = 1'b1;
      tick(1);
      code_vld = 1'b0;
      tick(2);
   endtask

   task automatic pulse_clr();
      flag_clr = 1'b1;
      tick(1);
      flag_clr = 1'b0;
      tick(1);
   endtask

   // nbits sclk periods at clk/8; collide raises code_vld so its capture lands on LOAD
   task automatic spi_frame(input int nbits, input bit collide, input logic [11:0] cw);
      cs_n = 1'b0;
      tick(3);
      if (collide) begin
         code_in  = cw;
         code_vld = 1'b1;
         tick(1);
         code_vld = 1'b0;
         tick(4);
      end else begin
         tick(5);
      end
      chk("tx_busy_in_frame", 16'(tx_busy), 16'd1);
      for (int i = 0; i < nbits; i++) begin
         sclk = 1'b1;
         tick(4);
         sclk = 1'b0;
         tick(4);
      end
      cs_n = 1'b1;
      tick(6);
      chk("tx_busy_idle", 16'(tx_busy), 16'd0);
      chk("miso_idle", 16'(miso), 16'd0);
   endtask

   int d0;

   initial begin
      tick(3);
      chk("rst_miso", 16'(miso), 16'd0);
      chk("rst_tx_busy", 16'(tx_busy), 16'd0);
      chk("rst_frame_done", 16'(frame_done), 16'd0);
      chk("rst_ovf", 16'(ovf), 16'd0);
      chk("rst_udf", 16'(udf), 16'd0);
      rst = 1'b0;
      tick(2);

      // Single frame; a level held high with a changing word must not recapture
      code_in  = 12'hA5C;
      code_vld = 1'b1;
      tick(1);
      code_in = 12'hFFF;
      tick(3);
      code_vld = 1'b0;
      tick(2);
      exp_q.push_back(frame_of(12'hA5C));
      d0 = done_cnt;
      spi_frame(NB, 1'b0, 12'h000);
      chk("single_done_cnt", 16'(done_cnt - d0), 16'd1);
      chk("single_udf", 16'(udf), 16'd0);
      chk("single_ovf", 16'(ovf), 16'd0);

      // Underrun; the EN=0 pulse must not capture
      EN = 1'b0;
      send_cw(12'h777);
      EN = 1'b1;
      exp_q.push_back(frame_of(12'h000));
      spi_frame(NB, 1'b0, 12'h000);
      chk("underrun_udf", 16'(udf), 16'd1);
      pulse_clr();
      chk("udf_cleared", 16'(udf), 16'd0);

      // Overflow: newest word wins
      send_cw(12'h111);
      send_cw(12'h222);
      chk("overflow_ovf", 16'(ovf), 16'd1);
      exp_q.push_back(frame_of(12'h222));
      spi_frame(NB, 1'b0, 12'h000);
      chk("overflow_udf", 16'(udf), 16'd0);
      pulse_clr();
      chk("ovf_cleared", 16'(ovf), 16'd0);

      // Abort after 5 sclk: no frame_done, word is gone
      send_cw(12'h5A5);
      d0 = done_cnt;
      spi_frame(5, 1'b0, 12'h000);
      chk("abort_no_done", 16'(done_cnt - d0), 16'd0);
      chk("abort_udf", 16'(udf), 16'd0);
      exp_q.push_back(frame_of(12'h000));
      spi_frame(NB, 1'b0, 12'h000);
      chk("after_abort_udf", 16'(udf), 16'd1);
      pulse_clr();

      // Collision: capture on the LOAD cycle
      send_cw(12'h0F0);
      exp_q.push_back(frame_of(12'h0F0));
      exp_q.push_back(frame_of(12'h3C3));
      spi_frame(NB, 1'b1, 12'h3C3);
      chk("collision_ovf", 16'(ovf), 16'd0);
      spi_frame(NB, 1'b0, 12'h000);
      chk("collision_udf", 16'(udf), 16'd0);
      chk("collision_ovf2", 16'(ovf), 16'd0);

      // Trailer words (plain 12-bit frames when the trailer is not built)
      send_cw(12'h001);
      exp_q.push_back(frame_of(12'h001));
      spi_frame(NB, 1'b0, 12'h000);
`ifdef HAMMING_TX_PARITY_TRAILER_EN
      chk("trailer_001", 16'(last_frame[0]), 16'd1);
`endif
      send_cw(12'h003);
      exp_q.push_back(frame_of(12'h003));
      spi_frame(NB, 1'b0, 12'h000);
`ifdef HAMMING_TX_PARITY_TRAILER_EN
      chk("trailer_003", 16'(last_frame[0]), 16'd0);
`endif

      tick(4);
      chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
